// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: shared state encoding, default constants and saturating increment for freq_meter
package freq_meter_pkg;

   localparam int GATE_CYCLES_DEF = 1000;
   localparam int EXP_COUNT_DEF   = 100;
   localparam int TOL_DEF         = 2;

   typedef enum logic [1:0] {IDLE, GATE, REPORT} state_t;

   // Increment that sticks at max instead of wrapping
   function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
      return (v == max) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/edge_sync.sv
// edge_sync: 2-flop synchronizer plus delay flop giving a synchronized level and a rising-edge strobe
module edge_sync (
   input  logic clk_100MHz,
   input  logic rst_n,
   input  logic d,
   output logic level,
   output logic rise
);

   logic [2:0] sr;

   // sr[0..1] resynchronize the asynchronous input, sr[2] is the one-cycle delay for edge detection
   always_ff @(posedge clk_100MHz or negedge rst_n)
      if (!rst_n) sr <= '0;
      else        sr <= {sr[1:0], d};

   assign level = sr[1];
   assign rise  = sr[1] & ~sr[2];

endmodule

// File: rtl/freq_meter.sv
// freq_meter: gated rising-edge counter with range check; define FREQ_METER_DUTY_EN to add high_out duty counter
module freq_meter
   import freq_meter_pkg::*;
#(
   parameter int GATE_CYCLES = GATE_CYCLES_DEF,
   parameter int CNT_W       = 16,
   parameter int EXP_COUNT   = EXP_COUNT_DEF,
   parameter int TOL         = TOL_DEF
) (
   input  logic             clk_100MHz,
   input  logic             rst_n,
   input  logic             meas_in,
   input  logic             start,
   input  logic             continuous,
   output logic             busy,
   output logic [CNT_W-1:0] count_out,
   output logic             count_valid,
   output logic             in_range,
   output logic             overflow
`ifdef FREQ_METER_DUTY_EN
   ,output logic [CNT_W-1:0] high_out
`endif
);

   localparam int GW = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
   localparam logic [GW-1:0]           GATE_LAST = GW'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0]        CNT_MAX   = '1;
   localparam logic signed [CNT_W:0]   EXP_S     = (CNT_W+1)'(EXP_COUNT);
   localparam logic [CNT_W:0]          TOL_U     = (CNT_W+1)'(TOL);

   state_t                 state, state_nx;
   logic [GW-1:0]          gate_cnt;
   logic [CNT_W-1:0]       edge_cnt;
   logic                   sat;
   logic                   clr;
   logic                   meas_rise;
   logic                   meas_lvl;
   logic signed [CNT_W:0]  diff;
   logic [CNT_W:0]         dev;

   edge_sync u_sync (
      .clk_100MHz (clk_100MHz),
      .rst_n      (rst_n),
      .d          (meas_in),
      .level      (meas_lvl),
      .rise       (meas_rise)
   );

   // Next state, counter clear on entry to a window, and deviation from the expected count
   always_comb begin
      state_nx = (state == IDLE) ? (start ? GATE : IDLE) :
                 (state == GATE) ? ((gate_cnt == GATE_LAST) ? REPORT : GATE) :
                 (continuous ? GATE : IDLE);
      clr  = (state_nx == GATE) && (state != GATE);
      diff = $signed({1'b0, edge_cnt}) - EXP_S;
      dev  = diff[CNT_W] ? -diff : diff;
   end

   assign busy = (state != IDLE);

   // State register
   always_ff @(posedge clk_100MHz or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;

   // Gate and edge counters; edges saturate and latch a lost-edge flag
   always_ff @(posedge clk_100MHz or negedge rst_n)
      if (!rst_n) begin
         gate_cnt <= '0;
         edge_cnt <= '0;
         sat      <= 1'b0;
      end else if (clr) begin
         gate_cnt <= '0;
         edge_cnt <= '0;
         sat      <= 1'b0;
      end else if (state == GATE) begin
         gate_cnt <= gate_cnt + 1'b1;
         if (meas_rise) begin
            edge_cnt <= CNT_W'(sat_inc(32'(edge_cnt), 32'(CNT_MAX)));
            sat      <= sat | (edge_cnt == CNT_MAX);
         end
      end

   // Result registers load in REPORT and hold until the next report; strobe marks the load
   always_ff @(posedge clk_100MHz or negedge rst_n)
      if (!rst_n) begin
         count_valid <= 1'b0;
         count_out   <= '0;
         overflow    <= 1'b0;
         in_range    <= 1'b0;
      end else begin
         count_valid <= (state == REPORT);
         if (state == REPORT) begin
            count_out <= edge_cnt;
            overflow  <= sat;
            in_range  <= (dev <= TOL_U);
         end
      end

`ifdef FREQ_METER_DUTY_EN
   logic [CNT_W-1:0] high_cnt;

   // Count gate cycles where the synchronized input is high, reported alongside the edge count
   always_ff @(posedge clk_100MHz or negedge rst_n)
      if (!rst_n) begin
         high_cnt <= '0;
         high_out <= '0;
      end else begin
         if (clr)                            high_cnt <= '0;
         else if (state == GATE && meas_lvl) high_cnt <= CNT_W'(sat_inc(32'(high_cnt), 32'(CNT_MAX)));
         if (state == REPORT)                high_out <= high_cnt;
      end
`else
   logic unused_lvl;
   assign unused_lvl = meas_lvl;
`endif

endmodule
